div: RTL

Sequential signed 32-bit divider, the counterpart of the multiplier in the MultDiv unit. On a `divControl` start pulse it divides `regA_out` (dividend) by `regB_out` (divisor) with a one-bit-per-cycle restoring algorithm on magnitudes, then applies signs. It writes the quotient to `lo_entrance` and the remainder to `hi_entrance` for the HI/LO registers, and flags division by zero to the control unit.

---
 rtl/multdiv_pkg.sv | 20 ++
 rtl/div_step.sv | 24 ++
 rtl/div.sv | 128 ++++++++++++
 3 files changed

// File: rtl/multdiv_pkg.sv
// Shared definitions for the MultDiv unit: operand width, iteration count,
// divider state encoding and a two's-complement magnitude helper.
package multdiv_pkg;

    localparam int WIDTH      = 32;
    localparam int ITERATIONS = 32;
    localparam int COUNT_W    = $clog2(ITERATIONS + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } div_state_t;

    // |0x80000000| wraps back to 0x80000000, which is the correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_trial;

    assign w_shifted = {i_rem, i_quo[WIDTH-1]};
    assign w_trial   = w_shifted - {1'b0, i_divisor};

    // The partial remainder stays below the divisor, so its 33rd bit is always zero
    // and only the low WIDTH bits are carried between iterations.
    assign o_rem = w_trial[WIDTH] ? w_shifted[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign o_quo = {i_quo[WIDTH-2:0], ~w_trial[WIDTH]};

endmodule

// File: rtl/div.sv
// Sequential signed divider for the MultDiv unit: restoring division on
// magnitudes over 32 cycles, then sign fix-up into the HI/LO entrance registers.
module div #(
    parameter int WIDTH = multdiv_pkg::WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] regA_out,
    input  logic [WIDTH-1:0] regB_out,
    input  logic             divControl,
    output logic [WIDTH-1:0] hi_entrance,
    output logic [WIDTH-1:0] lo_entrance,
    output logic             div_busy,
    output logic             div_done,
    output logic             div_zero
);
    import multdiv_pkg::*;

    div_state_t         r_state;
    div_state_t         w_next_state;
    logic               r_sa;
    logic               r_sb;
    logic               r_zero_pend;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_divisor;
    logic [COUNT_W-1:0] r_count;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;
    logic               r_zero;
    logic [WIDTH-1:0]   w_next_rem;
    logic [WIDTH-1:0]   w_next_quo;
    logic               w_start;
    logic               w_accept;
    logic               w_zero_req;

    // A zero-divisor request posts its status one cycle later; starts are held off meanwhile.
    assign w_start    = (r_state == IDLE) && divControl && !r_zero_pend;
    assign w_accept   = w_start && (regB_out != '0);
    assign w_zero_req = w_start && (regB_out == '0);

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_divisor),
        .o_rem     (w_next_rem),
        .o_quo     (w_next_quo)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = RUN;
            RUN:     if (r_count == COUNT_W'(1)) w_next_state = FIX;
            FIX:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sa        <= 1'b0;
            r_sb        <= 1'b0;
            r_zero_pend <= 1'b0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_divisor   <= '0;
            r_count     <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_zero      <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (r_zero_pend) begin
                r_zero_pend <= 1'b0;
                r_zero      <= 1'b1;
                r_done      <= 1'b1;
            end

            if (w_zero_req) r_zero_pend <= 1'b1;

            if (w_accept) begin
                r_sa      <= regA_out[WIDTH-1];
                r_sb      <= regB_out[WIDTH-1];
                r_rem     <= '0;
                r_quo     <= magnitude(regA_out);
                r_divisor <= magnitude(regB_out);
                r_count   <= COUNT_W'(ITERATIONS);
                r_zero    <= 1'b0;
                r_busy    <= 1'b1;
            end

            if (r_state == RUN) begin
                r_rem   <= w_next_rem;
                r_quo   <= w_next_quo;
                r_count <= r_count - COUNT_W'(1);
            end

            // Truncating division: the remainder carries the dividend's sign.
            if (r_state == FIX) begin
                r_lo   <= (r_sa ^ r_sb) ? -r_quo : r_quo;
                r_hi   <= r_sa ? -r_rem : r_rem;
                r_done <= 1'b1;
                r_busy <= 1'b0;
            end
        end
    end

    assign hi_entrance = r_hi;
    assign lo_entrance = r_lo;
    assign div_busy    = r_busy;
    assign div_done    = r_done;
    assign div_zero    = r_zero;

endmodule
